// File: rtl/decode_stage_buf.sv
// decode_stage_buf: decode + DEPTH-entry record FIFO; `DECODE_STATS_EN adds push/illegal counters
module decode_stage_buf #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                instr_i,
  input  logic [PC_W-1:0]            pc_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [PC_W-1:0]            pc_o,
  output logic [2:0]                 class_o,
  output logic [4:0]                 opcode_o,
  output logic [4:0]                 rd_o,
  output logic [4:0]                 rs1_o,
  output logic [4:0]                 rs2_o,
  output logic [DW-1:0]              imm_o,
  output logic                       rd_we_o,
  output logic                       rs1_used_o,
  output logic                       rs2_used_o,
  output logic                       illegal_o,
  output logic [$clog2(DEPTH):0]     occ_o,
  output logic [CNT_W-1:0]           dec_cnt_o,
  output logic [CNT_W-1:0]           ill_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [2:0]    cls;
    logic [4:0]    op;
    logic [DW-1:0] imm;
    logic [2:0]    use_f;
    logic          ill;
  } dec_t;
  function automatic dec_t decode(input logic [31:0] in);
    dec_t d;
    d.cls = in[31:29];
    d.op  = in[28:24];
    d.ill = (d.cls == 3'd7) ||
            (d.cls <= 3'd1 && d.op > 5'd8) ||
            ((d.cls == 3'd5 || d.cls == 3'd6) && d.op > 5'd3);
    d.imm = (d.ill || d.cls == 3'd0) ? '0 :
            d.cls == 3'd5 ? DW'($signed(in[18:0])) :
            d.cls == 3'd6 ? DW'(in[23:0]) :
                            DW'($signed(in[13:0]));
    d.use_f = d.ill          ? 3'b000 :
              d.cls == 3'd0  ? 3'b111 :
              d.cls <= 3'd2  ? 3'b110 :
              d.cls <= 3'd4  ? 3'b011 :
              d.cls == 3'd5  ? 3'b100 : 3'b000;
    return d;
  endfunction
  // Raw instructions are stored; the head entry is decoded on the way out.
  logic [31:0]     instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]     occ_q, occ_d;
  logic            push, pop;
  dec_t            head;
  assign in_ready_o  = (occ_q < (AW+1)'(DEPTH)) && !flush_i;
  assign out_valid_o = occ_q != '0;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i && !flush_i;
  always_comb begin
    wp_d  = flush_i ? '0 : wp_q + AW'(push);
    rp_d  = flush_i ? '0 : rp_q + AW'(pop);
    occ_d = flush_i ? '0 : occ_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      occ_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      occ_q <= occ_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wp_q] <= instr_i;
      pc_mem[wp_q]    <= pc_i;
    end
  end
  assign head       = decode(instr_mem[rp_q]);
  assign pc_o       = pc_mem[rp_q];
  assign class_o    = head.cls;
  assign opcode_o   = head.op;
  assign rd_o       = instr_mem[rp_q][23:19];
  assign rs1_o      = instr_mem[rp_q][18:14];
  assign rs2_o      = instr_mem[rp_q][13:9];
  assign imm_o      = head.imm;
  assign rd_we_o    = head.use_f[2];
  assign rs1_used_o = head.use_f[1];
  assign rs2_used_o = head.use_f[0];
  assign illegal_o  = head.ill;
  assign occ_o      = occ_q;
`ifdef DECODE_STATS_EN
  logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d, ill_cnt_q, ill_cnt_d;
  always_comb begin
    dec_cnt_d = (push && !(&dec_cnt_q)) ? dec_cnt_q + 1'b1 : dec_cnt_q;
    ill_cnt_d = (push && decode(instr_i).ill && !(&ill_cnt_q)) ? ill_cnt_q + 1'b1 : ill_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_q <= '0;
      ill_cnt_q <= '0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end
  assign dec_cnt_o = dec_cnt_q;
  assign ill_cnt_o = ill_cnt_q;
`else
  assign dec_cnt_o = '0;
  assign ill_cnt_o = '0;
`endif
endmodule

// File: doc/decode_stage_buf.md
Name: decode_stage_buf

Overview:
- Registered, parametrised successor to the single-cycle instruction decoder.
- Decodes one 32-bit instruction per accepted transfer and writes the decoded record into a DEPTH-entry FIFO. Downstream pops records through a valid/ready handshake.
- Adds features the single-cycle decoder lacks: sign-extended immediates, register-use flags, illegal-instruction detection, flush and occupancy.
- Sits between instruction fetch and the issue/execute stage.

Parameters:
- DEPTH, 2, FIFO entries; power of two, >= 2.
- DW, 32, data width of imm_o; must be >= 24.
- PC_W, 32, width of the PC carried alongside each instruction.
- CNT_W, 16, width of the statistics counters (optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of all buffered records.
- in_valid_i  in  1  upstream has an instruction.
- in_ready_o  out  1  stage can accept an instruction.
- instr_i  in  32  raw instruction.
- pc_i  in  PC_W  PC of instr_i.
- out_valid_o  out  1  head record valid.
- out_ready_i  in  1  downstream accepts the head record.
- pc_o  out  PC_W  PC of the head record.
- class_o  out  3  {bc,ct}.
- opcode_o  out  5  opcode.
- rd_o  out  5  destination register.
- rs1_o  out  5  source register 1.
- rs2_o  out  5  source register 2.
- imm_o  out  DW  extended immediate.
- rd_we_o  out  1  rd is written.
- rs1_used_o  out  1  rs1 is read.
- rs2_used_o  out  1  rs2 is read.
- illegal_o  out  1  instruction is illegal.
- occ_o  out  $clog2(DEPTH)+1  number of buffered records.
- dec_cnt_o  out  CNT_W  count of accepted instructions (optional feature).
- ill_cnt_o  out  CNT_W  count of accepted illegal instructions (optional feature).

Behaviour:
- Field layout:
  - bc = [31:30], ct = [29], opcode = [28:24].
  - rd = [23:19], rs1 = [18:14], rs2 = [13:9].
  - imm14 = [13:0], imm19 = [18:0], sysop = [23:0].
- Class encoding:
  - 000 ALU_R, 001 ALU_I, 010 LOAD, 011 STORE.
  - 100 BRANCH, 101 JUMP, 110 SYSTEM, 111 reserved.
- Illegal when any of:
  - class = 111;
  - ALU_R or ALU_I with opcode > 8 (0..8 = ADD, ADDU, SUB, MUL, SMUL, DIV, IDIV, AND, OR);
  - JUMP or SYSTEM with opcode > 3.
- imm_o:
  - ALU_R: 0.
  - ALU_I, LOAD, STORE, BRANCH: imm14 sign-extended to DW.
  - JUMP: imm19 sign-extended.
  - SYSTEM: sysop zero-extended.
  - Illegal: 0.
- Use flags as {rd_we, rs1_used, rs2_used}:
  - ALU_R 111, ALU_I 110, LOAD 110, STORE 011.
  - BRANCH 011, JUMP 100, SYSTEM 000, illegal 000.
- rd_o, rs1_o and rs2_o always carry the raw fields, even when the corresponding flag is 0.
- Handshake:
  - Push when in_valid_i && in_ready_o.
  - Pop when out_valid_o && out_ready_i.
  - Upstream must hold instr_i and pc_i stable while in_valid_i is high and in_ready_o is low.
- Flow control:
  - in_ready_o = (occ < DEPTH) && !flush_i.
  - out_valid_o = (occ != 0).
  - Output fields are read combinationally from the head entry.
- Latency: an instruction pushed at edge N is visible at the outputs after edge N (one cycle). There is no combinational input-to-output bypass.
- Simultaneous push and pop when not full: occupancy is unchanged and both pointers advance.
- Full: in_ready_o is low, even if a pop happens in the same cycle; there is no pass-through when full.
- Empty: out_valid_o is low and output fields are don't-care. The bench must check fields only when out_valid_o is high.
- Pointers are log2(DEPTH) bits and wrap naturally.
- flush_i high at an edge:
  - pointers and occupancy go to 0;
  - no push occurs, and any pop that cycle is discarded;
  - counters are unaffected.
- Reset (rst_n low, asynchronous):
  - pointers = 0, occ_o = 0, out_valid_o = 0, in_ready_o = 1 once rst_n is high;
  - counters = 0.
  - Storage contents are not reset.
- Reset asserted mid-transfer drops every buffered record.

Optional Feature:
- Macro: DECODE_STATS_EN.
- Defined:
  - dec_cnt_o increments on every push.
  - ill_cnt_o increments on every push with illegal = 1.
  - Both counters saturate at 2^CNT_W - 1 and clear only on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- ADD, reg fields 3/1/2: push 32'b00_0_00000_00011_00001_00010_0000_00000.
  - Next cycle: class 000, opcode 0, rd 3, rs1 1, rs2 2, flags 111, imm 0, illegal 0.
- Negative immediate: push ALU_I with imm14 = 14'h3FFF.
  - imm_o = 32'hFFFFFFFF, flags 110.
- Long immediates:
  - JUMP with imm19 = 19'h40000 -> imm_o = 32'hFFFC0000, flags 100.
  - SYSTEM with sysop = 24'h800000 -> imm_o = 32'h00800000.
- Illegal detection, four pushes:
  - class 111;
  - ALU_R opcode 9;
  - JUMP opcode 4;
  - SYSTEM opcode 3.
  - Expect illegal 1, 1, 1, 0.
  - With DECODE_STATS_EN: dec_cnt 4, ill_cnt 3.
- Back-pressure with DEPTH=2, out_ready_i = 0:
  - Push 3 instructions: third stalls, in_ready_o 0, occ 2.
  - Assert out_ready_i: records pop in order.
  - Continuous push+pop keeps occ 1 with no gaps.
- Flush and reset:
  - occ 2 plus flush_i with in_valid_i high -> occ 0, nothing accepted that cycle.
  - Drop rst_n asynchronously mid-stream -> out_valid_o falls immediately, occ 0.
